// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared sizing constants and FSM encoding for the ADC scan scheduler
package adc_pkg;

  localparam int NUM_CH      = 8;
  localparam int ADC_W       = 10;
  localparam int CH_W        = 3;
  localparam int TIMEOUT_CYC = 1023;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEL   = 2'd1,
    ST_CONV  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

endpackage

// File: rtl/adc_rr_next.sv
// rtl/adc_rr_next.sv - lowest enabled channel at or above a pass pointer
module adc_rr_next #(
  parameter int NUM_CH = adc_pkg::NUM_CH
) (
  input  logic [NUM_CH-1:0]          mask,
  input  logic [adc_pkg::CH_W:0]     pointer,
  output logic                       found,
  output logic [adc_pkg::CH_W-1:0]   ch
);
  import adc_pkg::*;

  // walk from the top down so the last hit kept is the lowest eligible channel
  always_comb begin
    found = 1'b0;
    ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(pointer))) begin
        found = 1'b1;
        ch    = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/adc_scan_sched.sv
// rtl/adc_scan_sched.sv - masked multi-channel ADC scan scheduler with timeout and continuous mode
module adc_scan_sched #(
  parameter int NUM_CH      = adc_pkg::NUM_CH,
  parameter int ADC_W       = adc_pkg::ADC_W,
  parameter int TIMEOUT_CYC = adc_pkg::TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      cont,
  input  logic [NUM_CH-1:0]         chan_mask,
  input  logic                      adc_done,
  input  logic [ADC_W-1:0]          adc_data,
  output logic                      adc_en,
  output logic [adc_pkg::CH_W-1:0]  adc_ch,
  output logic                      res_valid,
  output logic [adc_pkg::CH_W-1:0]  res_ch,
  output logic [ADC_W-1:0]          res_data,
  output logic                      busy,
  output logic                      scan_done,
  output logic                      timeout_err
);
  import adc_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CH_W:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   res_ch_q, res_ch_d;
  logic [ADC_W-1:0]  data_q, data_d;
  logic              done_q, done_d;
  logic              tmo_q, tmo_d;
  logic              rr_found;
  logic [CH_W-1:0]   rr_ch;
  logic              advance;

  adc_rr_next #(.NUM_CH(NUM_CH)) u_rr (
    .mask    (mask_q),
    .pointer (ptr_q),
    .found   (rr_found),
    .ch      (rr_ch)
  );

  // state and datapath registers; reset parks everything at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      ch_q     <= '0;
      res_ch_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ch_q     <= ch_d;
      res_ch_q <= res_ch_d;
      data_q   <= data_d;
      done_q   <= done_d;
      tmo_q    <= tmo_d;
    end
  end

  // next-state logic; a finished or timed-out conversion shares the pass-advance path
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ch_d     = ch_q;
    res_ch_d = res_ch_q;
    data_d   = data_q;
    done_d   = 1'b0;
    tmo_d    = 1'b0;
    advance  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && (chan_mask != '0)) begin
          mask_d  = chan_mask;
          ptr_d   = '0;
          state_d = ST_SEL;
        end
      end
      ST_SEL: begin
        ch_d    = rr_ch;
        ptr_d   = (CH_W+1)'(rr_ch) + (CH_W+1)'(1);
        cnt_d   = CNT_W'(1);
        state_d = ST_CONV;
      end
      ST_CONV: begin
        if (adc_done) begin
          data_d   = adc_data;
          res_ch_d = ch_q;
          state_d  = ST_STORE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
          tmo_d   = 1'b1;
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STORE: begin
        advance = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (rr_found) begin
        state_d = ST_SEL;
      end else if (cont && (chan_mask != '0)) begin
        mask_d  = chan_mask;
        ptr_d   = '0;
        state_d = ST_SEL;
      end else begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end

    // abort outranks a completing conversion and suppresses every pulse
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      data_d   = data_q;
      res_ch_d = res_ch_q;
      done_d   = 1'b0;
      tmo_d    = 1'b0;
    end
  end

  assign adc_en      = (state_q == ST_CONV);
  assign adc_ch      = (state_q == ST_SEL) ? rr_ch : ch_q;
  assign res_valid   = (state_q == ST_STORE) && !abort;
  assign res_ch      = res_ch_q;
  assign res_data    = data_q;
  assign busy        = (state_q != ST_IDLE);
  assign scan_done   = done_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_adc_scan_sched.sv
// tb/tb_adc_scan_sched.sv - directed self-checking bench for adc_scan_sched
module tb_adc_scan_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       cont;
  logic [7:0] chan_mask;
  logic       adc_done;
  logic [9:0] adc_data;
  logic       adc_en;
  logic [2:0] adc_ch;
  logic       res_valid;
  logic [2:0] res_ch;
  logic [9:0] res_data;
  logic       busy;
  logic       scan_done;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;

  adc_scan_sched #(.NUM_CH(8), .ADC_W(10), .TIMEOUT_CYC(1023)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cont        (cont),
    .chan_mask   (chan_mask),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .adc_en      (adc_en),
    .adc_ch      (adc_ch),
    .res_valid   (res_valid),
    .res_ch      (res_ch),
    .res_data    (res_data),
    .busy        (busy),
    .scan_done   (scan_done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // ADC model: answers 10'h3A7 + channel after model_lat extra CONV cycles
  bit model_en = 1'b0;
  int model_lat = 1;
  int conv_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (model_en) begin
      if (adc_en && !adc_done) begin
        if (conv_cnt >= model_lat) begin
          adc_done = 1'b1;
          adc_data = 10'h3A7 + {7'b0, adc_ch};
          conv_cnt = 0;
        end else begin
          conv_cnt++;
        end
      end else begin
        adc_done = 1'b0;
        conv_cnt = 0;
      end
    end
  end

  // monitor: collects results, pulse counts and protocol violations
  typedef struct { logic [2:0] ch; logic [9:0] data; } res_t;
  res_t res_q[$];
  int scan_done_cnt = 0;
  int timeout_cnt = 0;
  int en_run = 0;
  int last_run = 0;
  int lat_err = 0;
  int gap_err = 0;
  logic prev_done = 1'b0;
  logic prev_en = 1'b0;
  logic [2:0] prev_ch = 3'd0;
  always @(negedge clk) begin
    res_t r;
    if (res_valid) begin
      r.ch = res_ch;
      r.data = res_data;
      res_q.push_back(r);
      if (!prev_done) lat_err++;
    end
    if (scan_done) scan_done_cnt++;
    if (timeout_err) timeout_cnt++;
    if (prev_done && adc_en) gap_err++;
    if (prev_en && adc_en && (adc_ch != prev_ch)) gap_err++;
    if (adc_en) begin
      en_run++;
    end else begin
      if (prev_en) last_run = en_run;
      en_run = 0;
    end
    prev_done = adc_done;
    prev_en = adc_en;
    prev_ch = adc_ch;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [7:0] m);
    chan_mask = m;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_res(input int n, input int budget, output bit ok);
    int k = 0;
    while ((res_q.size() < n) && (k < budget)) begin
      tick;
      k++;
    end
    ok = (res_q.size() >= n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while (busy && (k < budget)) begin
      tick;
      k++;
    end
    ok = !busy;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cont = 1'b0;
    chan_mask = 8'h00; adc_done = 1'b0; adc_data = 10'h000;
    repeat (3) tick;
    checks++;
    if ({adc_en, adc_ch, res_valid, res_ch, res_data, busy, scan_done, timeout_err} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got %b want all zero",
               {adc_en, adc_ch, res_valid, res_ch, res_data, busy, scan_done, timeout_err});
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
  endtask

  task automatic test_basic_scan;
    logic [2:0] exp_ch [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    logic [9:0] exp_d  [4] = '{10'h3A7, 10'h3A9, 10'h3AC, 10'h3AE};
    int sd0 = scan_done_cnt;
    int t0 = timeout_cnt;
    bit ok;
    model_en = 1'b1; model_lat = 2; cont = 1'b0;
    res_q.delete();
    pulse_start(8'hA5);
    repeat (4) tick;
    pulse_start(8'h01);
    wait_idle(300, ok);
    tick;
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_idle busy=%b want 0 within budget", busy); end
    checks++;
    if (res_q.size() != 4) begin errors++; $display("FAIL basic_count got %0d want 4", res_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((res_q[i].ch !== exp_ch[i]) || (res_q[i].data !== exp_d[i])) begin
        errors++;
        $display("FAIL basic_res%0d got ch %0d data %h want ch %0d data %h",
                 i, res_q[i].ch, res_q[i].data, exp_ch[i], exp_d[i]);
      end
    end
    checks++;
    if (scan_done_cnt - sd0 != 1) begin errors++; $display("FAIL basic_scan_done got %0d want 1", scan_done_cnt - sd0); end
    checks++;
    if (timeout_cnt != t0) begin errors++; $display("FAIL basic_timeout got %0d want %0d", timeout_cnt, t0); end
  endtask

  task automatic test_cont_abort;
    logic [2:0] exp_ch [6] = '{3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7};
    int sd0 = scan_done_cnt;
    bit ok;
    model_en = 1'b1; model_lat = 1; cont = 1'b1;
    res_q.delete();
    pulse_start(8'h81);
    wait_res(6, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL cont_wait got %0d results want 6", res_q.size()); end
    tick;
    checks++;
    if (adc_en !== 1'b1) begin errors++; $display("FAIL cont_conv_before_abort adc_en=%b want 1", adc_en); end
    abort = 1'b1;
    tick;
    checks++;
    if ((adc_en !== 1'b0) || (busy !== 1'b0)) begin
      errors++; $display("FAIL cont_abort adc_en=%b busy=%b want 0 0", adc_en, busy);
    end
    abort = 1'b0; cont = 1'b0;
    repeat (5) tick;
    checks++;
    if (res_q.size() != 6) begin errors++; $display("FAIL cont_count got %0d want 6", res_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ((res_q[i].ch !== exp_ch[i]) || (res_q[i].data !== (exp_ch[i] == 3'd0 ? 10'h3A7 : 10'h3AE))) begin
        errors++;
        $display("FAIL cont_res%0d got ch %0d data %h want ch %0d", i, res_q[i].ch, res_q[i].data, exp_ch[i]);
      end
    end
    checks++;
    if (scan_done_cnt != sd0) begin errors++; $display("FAIL cont_scan_done got %0d want %0d", scan_done_cnt, sd0); end
  endtask

  task automatic test_timeout;
    int sd0 = scan_done_cnt;
    int t0 = timeout_cnt;
    int k = 0;
    model_en = 1'b0; adc_done = 1'b0; cont = 1'b0;
    res_q.delete();
    pulse_start(8'h04);
    while (!timeout_err && (k < 1200)) begin tick; k++; end
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_seen got %b want 1 within budget", timeout_err); end
    repeat (2) tick;
    checks++;
    if (last_run != 1023) begin errors++; $display("FAIL tmo_conv_cycles got %0d want 1023", last_run); end
    checks++;
    if (res_q.size() != 0) begin errors++; $display("FAIL tmo_res got %0d want 0", res_q.size()); end
    checks++;
    if (timeout_cnt - t0 != 1) begin errors++; $display("FAIL tmo_pulses got %0d want 1", timeout_cnt - t0); end
    checks++;
    if ((scan_done_cnt - sd0 != 1) || (busy !== 1'b0)) begin
      errors++; $display("FAIL tmo_scan_done got %0d busy %b want 1 0", scan_done_cnt - sd0, busy);
    end
  endtask

  task automatic test_mask_change;
    bit ok;
    model_en = 1'b1; model_lat = 1; cont = 1'b1;
    res_q.delete();
    pulse_start(8'h0F);
    wait_res(2, 100, ok);
    chan_mask = 8'hF0;
    wait_res(8, 300, ok);
    abort = 1'b1;
    tick;
    abort = 1'b0; cont = 1'b0;
    repeat (3) tick;
    checks++;
    if (res_q.size() != 8) begin errors++; $display("FAIL mask_count got %0d want 8", res_q.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ((res_q[i].ch !== 3'(i)) || (res_q[i].data !== (10'h3A7 + 10'(i)))) begin
        errors++;
        $display("FAIL mask_res%0d got ch %0d data %h want ch %0d", i, res_q[i].ch, res_q[i].data, i);
      end
    end
  endtask

  task automatic test_reset_conv;
    int sd0;
    int t0;
    model_en = 1'b0; adc_done = 1'b0; cont = 1'b0;
    res_q.delete();
    pulse_start(8'h04);
    repeat (5) tick;
    checks++;
    if ((adc_en !== 1'b1) || (adc_ch !== 3'd2)) begin
      errors++; $display("FAIL rstconv_pre adc_en=%b adc_ch=%0d want 1 2", adc_en, adc_ch);
    end
    rst_n = 1'b0;
    tick;
    checks++;
    if ({adc_en, adc_ch, res_valid, res_ch, res_data, busy, scan_done, timeout_err} !== 20'h0) begin
      errors++;
      $display("FAIL rstconv_outputs got %b want all zero",
               {adc_en, adc_ch, res_valid, res_ch, res_data, busy, scan_done, timeout_err});
    end
    rst_n = 1'b1;
    tick;
    sd0 = scan_done_cnt;
    t0 = timeout_cnt;
    pulse_start(8'h00);
    checks++;
    if ({adc_en, adc_ch, res_valid, res_ch, res_data, busy, scan_done, timeout_err} !== 20'h0) begin
      errors++;
      $display("FAIL zero_mask_outputs got %b want all zero",
               {adc_en, adc_ch, res_valid, res_ch, res_data, busy, scan_done, timeout_err});
    end
    repeat (4) tick;
    checks++;
    if ((busy !== 1'b0) || (res_q.size() != 0) || (scan_done_cnt != sd0) || (timeout_cnt != t0)) begin
      errors++;
      $display("FAIL zero_mask_activity busy=%b res=%0d sd=%0d tmo=%0d want 0 0 %0d %0d",
               busy, res_q.size(), scan_done_cnt, timeout_cnt, sd0, t0);
    end
  endtask

  task automatic test_coincident;
    int sd0 = scan_done_cnt;
    int t0 = timeout_cnt;
    int n = 0;
    int k = 0;
    int r0;
    model_en = 1'b0; adc_done = 1'b0; cont = 1'b0;
    res_q.delete();
    pulse_start(8'h04);
    while ((n < 1023) && (k < 1100)) begin
      tick;
      k++;
      if (adc_en) n++;
    end
    checks++;
    if (n != 1023) begin errors++; $display("FAIL coin_reach got %0d conv cycles want 1023", n); end
    adc_done = 1'b1;
    adc_data = 10'h155;
    tick;
    adc_done = 1'b0;
    checks++;
    if ((res_valid !== 1'b1) || (res_ch !== 3'd2) || (res_data !== 10'h155) || (timeout_err !== 1'b0)) begin
      errors++;
      $display("FAIL coin_done_wins got v=%b ch=%0d d=%h tmo=%b want 1 2 155 0",
               res_valid, res_ch, res_data, timeout_err);
    end
    repeat (2) tick;
    checks++;
    if ((timeout_cnt != t0) || (scan_done_cnt - sd0 != 1) || (busy !== 1'b0)) begin
      errors++;
      $display("FAIL coin_after tmo=%0d sd=%0d busy=%b want %0d 1 0", timeout_cnt, scan_done_cnt - sd0, busy, t0);
    end
    sd0 = scan_done_cnt;
    r0 = res_q.size();
    pulse_start(8'h04);
    repeat (3) tick;
    checks++;
    if (adc_en !== 1'b1) begin errors++; $display("FAIL coin_abort_pre adc_en=%b want 1", adc_en); end
    adc_done = 1'b1;
    adc_data = 10'h2AA;
    abort = 1'b1;
    tick;
    checks++;
    if ((res_valid !== 1'b0) || (adc_en !== 1'b0) || (busy !== 1'b0)) begin
      errors++;
      $display("FAIL coin_abort_wins got v=%b en=%b busy=%b want 0 0 0", res_valid, adc_en, busy);
    end
    adc_done = 1'b0;
    abort = 1'b0;
    repeat (3) tick;
    checks++;
    if ((res_q.size() != r0) || (scan_done_cnt != sd0) || (timeout_cnt != t0)) begin
      errors++;
      $display("FAIL coin_abort_after res=%0d sd=%0d tmo=%0d want %0d %0d %0d",
               res_q.size(), scan_done_cnt, timeout_cnt, r0, sd0, t0);
    end
  endtask

  task automatic test_protocol;
    checks++;
    if (lat_err != 0) begin errors++; $display("FAIL res_latency violations %0d want 0", lat_err); end
    checks++;
    if (gap_err != 0) begin errors++; $display("FAIL adc_en_gap violations %0d want 0", gap_err); end
  endtask

  initial begin
    test_reset;
    test_basic_scan;
    test_cont_abort;
    test_timeout;
    test_mask_change;
    test_reset_conv;
    test_coincident;
    test_protocol;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_sched.md
ADC_SCAN_SCHED -- requirements
Module: adc_scan_sched

Interface
REQ-001 Parameter NUM_CH, default 8: number of ADC input channels, selected by a 3-bit code.
REQ-002 Parameter ADC_W, default 10: conversion result width.
REQ-003 Parameter TIMEOUT_CYC, default 1023: maximum clk cycles allowed from adc_en rise to adc_done.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a scan.
REQ-007 abort  in  1  level; terminates any scan.
REQ-008 cont  in  1  continuous mode; repeat passes until abort or an empty mask.
REQ-009 chan_mask  in  NUM_CH  channel enable bits; bit i selects channel i.
REQ-010 adc_done  in  1  conversion-complete strobe from the ADC interface.
REQ-011 adc_data  in  ADC_W  conversion result; valid while adc_done=1.
REQ-012 adc_en  out  1  conversion request (level) to the ADC interface.
REQ-013 adc_ch  out  3  channel select code to the ADC interface (I3..I1).
REQ-014 res_valid  out  1  one-cycle result strobe.
REQ-015 res_ch  out  3  channel number of the result.
REQ-016 res_data  out  ADC_W  result value.
REQ-017 busy  out  1  high whenever the FSM is not in IDLE.
REQ-018 scan_done  out  1  one-cycle pulse when a scan ends normally.
REQ-019 timeout_err  out  1  one-cycle pulse when a conversion times out.

Function
REQ-020 FSM states SHALL be: IDLE, SEL, CONV, STORE.
REQ-021 In IDLE, start=1 with chan_mask!=0 SHALL latch chan_mask, clear the pass pointer, and go to SEL; a zero mask SHALL leave the FSM in IDLE with no output pulses.
REQ-022 start while busy=1 SHALL be ignored.
REQ-023 SEL (one cycle, adc_en=0) SHALL pick the lowest set latched-mask bit at or above the pointer, drive adc_ch to that channel, set the pointer to channel+1, and go to CONV.
REQ-024 CONV SHALL hold adc_en=1 and adc_ch stable and increment the timeout counter each cycle.
REQ-025 In CONV, adc_done=1 SHALL register adc_data and the channel, deassert adc_en, and go to STORE.
REQ-026 In CONV, a counter value of TIMEOUT_CYC without adc_done SHALL pulse timeout_err, skip the channel with no res_valid, and proceed as if leaving STORE.
REQ-027 If adc_done and the timeout occur in the same cycle, adc_done SHALL win.
REQ-028 STORE SHALL assert res_valid, res_ch and res_data for exactly one cycle; conversion-to-res_valid latency SHALL be 1 cycle after adc_done.
REQ-029 After STORE, the FSM SHALL go to SEL if any latched-mask bit at or above the pointer remains set.
REQ-030 At the end of a pass with cont=1, chan_mask SHALL be re-latched, the pointer wrapped to 0, and the FSM sent to SEL.
REQ-031 At the end of a pass with cont=0, or with cont=1 and a re-latched mask of 0, the FSM SHALL pulse scan_done and go to IDLE.
REQ-032 Changes to chan_mask mid-pass SHALL have no effect until the next pass boundary.
REQ-033 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with adc_en=0 and no res_valid or scan_done; abort SHALL take priority over adc_done.
REQ-034 adc_en SHALL be low for at least one cycle between consecutive conversions.

Reset
REQ-035 rst_n=0 at a clock edge SHALL force IDLE and clear the latched mask, pointer, and counter; all outputs SHALL be 0 (adc_ch=0, res_data=0).
REQ-036 A reset taken mid-conversion SHALL drop adc_en on that same edge; no result SHALL be emitted afterwards.

Structure
REQ-037 The shared package adc_pkg SHALL hold ADC_W, NUM_CH, CH_W=3, TIMEOUT_CYC, and the FSM state encoding.
REQ-038 The masked round-robin next-channel finder SHALL be the sub-module adc_rr_next (inputs: mask, pointer; outputs: found, ch), combinational only.

Verification
REQ-039 Mask 8'b1010_0101, cont=0, start; the ADC model returns 10'h3A7 + ch -> results for channels 0, 2, 5, 7 in order with the correct data, then one scan_done and busy=0.
REQ-040 Mask 8'h81, cont=1, run 3 passes, then abort -> sequence 0, 7, 0, 7, 0, 7; adc_en low the cycle after abort; no scan_done.
REQ-041 Mask 8'h04, ADC never returns done -> timeout_err after exactly TIMEOUT_CYC CONV cycles; no res_valid; scan_done follows.
REQ-042 Change the mask from 8'h0F to 8'hF0 mid-pass with cont=1 -> first pass covers channels 0-3, second pass covers channels 4-7.
REQ-043 rst_n low while in CONV, and start with mask=0 -> all outputs 0 on the next edge; mask=0 start produces no activity.
REQ-044 adc_done coincident with the timeout and with abort -> adc_done wins over the timeout; abort wins over adc_done.
